// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debouncer.
// The optional edge-pulse outputs are enabled by defining DEBOUNCE_EDGE_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 8;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: metastability synchroniser, qualification FSM and counter.
// When DEBOUNCE_EDGE_EN is defined the channel also produces registered
// one-cycle rise/fall pulses aligned with changes of the clean level.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  deb_state_t             state;
  deb_state_t             state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   clean_nxt;

  // Shift the raw level through the synchroniser chain; the last flop is the safe sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Qualify a new level: it must hold until the counter reaches its top value.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = clean;
    case (state)
      ST_LO: begin
        if (s) begin
          state_nxt = PEND_HI;
          cnt_nxt   = '0;
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_nxt = ST_LO;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_HI;
          clean_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!s) begin
          state_nxt = PEND_LO;
          cnt_nxt   = '0;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_nxt = ST_HI;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_LO;
          clean_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_LO;
      end
    endcase
  end

  // Register FSM state, counter and the clean level together so the output never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LO;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Pulse for one cycle on the same edge the clean level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= clean_nxt & ~clean;
      fall <= ~clean_nxt & clean;
    end
  end
`endif

endmodule

// File: rtl/input_debouncer.sv
// Top level: WIDTH fully independent debounce channels.
// Define DEBOUNCE_EDGE_EN to add the rise_o/fall_o edge-pulse ports.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`endif
);

  // One channel instance per input bit; channels share only clock and reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_in[i]),
      .clean(clean_out[i])
`ifdef DEBOUNCE_EDGE_EN
      ,
      .rise (rise_o[i]),
      .fall (fall_o[i])
`endif
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer (default 2 channels, 2 sync stages, 8 cycles).
// Edge-pulse checks are included when DEBOUNCE_EDGE_EN is defined.
module tb_input_debouncer;

  logic       clk;
  logic       rst_n;
  logic [1:0] raw_in;
  logic [1:0] clean_out;
`ifdef DEBOUNCE_EDGE_EN
  logic [1:0] rise_o;
  logic [1:0] fall_o;
`endif

  int checks;
  int fails;

  input_debouncer #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (raw_in),
    .clean_out(clean_out)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .rise_o   (rise_o),
    .fall_o   (fall_o)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [1:0] value);
    raw_in = value;
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkEdges(input string tag, input logic [1:0] exp_rise, input logic [1:0] exp_fall);
`ifdef DEBOUNCE_EDGE_EN
    checkOutput({tag, "_rise"}, rise_o, exp_rise);
    checkOutput({tag, "_fall"}, fall_o, exp_fall);
`else
    if (exp_rise === 2'bxx || exp_fall === 2'bxx) $display("[TB] unexpected unknown edge expectation in %s", tag);
`endif
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    applyStimulus(2'b11);

    // 1: reset holds outputs low, then full latency after release
    #2;
    checkOutput("reset_async_clean", clean_out, 2'b00);
    tick(4);
    checkOutput("reset_held_clean", clean_out, 2'b00);
    checkEdges("reset_held", 2'b00, 2'b00);
    rst_n = 1'b1;
    tick(10);
    checkOutput("release_edge10", clean_out, 2'b00);
    tick(1);
    checkOutput("release_edge11", clean_out, 2'b11);
    checkEdges("release_edge11", 2'b11, 2'b00);
    tick(1);
    checkEdges("release_edge12", 2'b00, 2'b00);

    // return both channels low
    applyStimulus(2'b00);
    tick(10);
    checkOutput("fall_edge10", clean_out, 2'b11);
    tick(1);
    checkOutput("fall_edge11", clean_out, 2'b00);
    checkEdges("fall_edge11", 2'b00, 2'b11);
    tick(1);
    checkEdges("fall_edge12", 2'b00, 2'b00);

    // 2: step on channel 0 only
    applyStimulus(2'b01);
    tick(10);
    checkOutput("step_edge10", clean_out, 2'b00);
    checkEdges("step_edge10", 2'b00, 2'b00);
    tick(1);
    checkOutput("step_edge11", clean_out, 2'b01);
    checkEdges("step_edge11", 2'b01, 2'b00);
    tick(1);
    checkOutput("step_edge12", clean_out, 2'b01);
    checkEdges("step_edge12", 2'b00, 2'b00);

    // 3: 5-cycle glitch on channel 1 is rejected
    applyStimulus(2'b11);
    tick(5);
    applyStimulus(2'b01);
    for (int k = 0; k < 15; k++) begin
      tick(1);
      checkOutput("glitch5", clean_out, 2'b01);
      checkEdges("glitch5", 2'b00, 2'b00);
    end

    // 4a: s high on exactly 8 edges is rejected
    applyStimulus(2'b11);
    tick(8);
    applyStimulus(2'b01);
    for (int k = 0; k < 15; k++) begin
      tick(1);
      checkOutput("boundary8", clean_out, 2'b01);
    end

    // 4b: s high on 9 edges is accepted, then released
    applyStimulus(2'b11);
    tick(9);
    applyStimulus(2'b01);
    tick(1);
    checkOutput("boundary9_edge10", clean_out, 2'b01);
    tick(1);
    checkOutput("boundary9_edge11", clean_out, 2'b11);
    checkEdges("boundary9_edge11", 2'b10, 2'b00);
    tick(8);
    checkOutput("boundary9_edge19", clean_out, 2'b11);
    tick(1);
    checkOutput("boundary9_edge20", clean_out, 2'b01);
    checkEdges("boundary9_edge20", 2'b00, 2'b10);

    // bring channel 0 low before the bounce test
    applyStimulus(2'b00);
    tick(11);
    checkOutput("pre_bounce_low", clean_out, 2'b00);

    // 5: channel 0 toggles every 3 cycles, then settles high
    for (int k = 0; k < 14; k++) begin
      applyStimulus((k % 2 == 0) ? 2'b01 : 2'b00);
      for (int j = 0; j < 3; j++) begin
        tick(1);
        checkOutput("bounce", clean_out, 2'b00);
        checkEdges("bounce", 2'b00, 2'b00);
      end
    end
    applyStimulus(2'b01);
    tick(10);
    checkOutput("settle_edge10", clean_out, 2'b00);
    tick(1);
    checkOutput("settle_edge11", clean_out, 2'b01);
    checkEdges("settle_edge11", 2'b01, 2'b00);
    tick(1);
    checkEdges("settle_edge12", 2'b00, 2'b00);

    // 6: reset while channel 1 is pending at cnt=5
    applyStimulus(2'b11);
    tick(8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_clean", clean_out, 2'b00);
    checkEdges("midrun_reset", 2'b00, 2'b00);
    tick(2);
    checkOutput("midrun_reset_held", clean_out, 2'b00);
    rst_n = 1'b1;
    tick(10);
    checkOutput("midrun_release_edge10", clean_out, 2'b00);
    tick(1);
    checkOutput("midrun_release_edge11", clean_out, 2'b11);
    checkEdges("midrun_release_edge11", 2'b11, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
